// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: sequences new-game, serve delay, play and game-over,
// keeps BCD scores and drives gra_still back to the graphics block.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int SERVE_TICKS = 120,
    parameter int OVER_TICKS  = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       pts_1,
    input  logic       pts_2,
    output logic       gra_still,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic       new_game,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {NEWGAME, SERVE, PLAY, OVER} state_t;

    localparam logic [7:0] SERVE_T = 8'(SERVE_TICKS);
    localparam logic [7:0] OVER_T  = 8'(OVER_TICKS);
    localparam logic [7:0] WIN_BCD = 8'(((WIN_SCORE / 10) * 16) + (WIN_SCORE % 10));

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic [7:0] score1_nxt, score2_nxt;
    logic       armed, armed_nxt;
    logic       winner_nxt;
    logic       tick;
    logic       won;
    logic [7:0] inc1, inc2;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // One pulse per frame, just after the last visible line.
    assign tick = (y == 10'd481) && (x == 10'd0);
    assign inc1 = bcd_inc(score1);
    assign inc2 = bcd_inc(score2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= NEWGAME;
            timer  <= 8'd0;
            armed  <= 1'b0;
            score1 <= 8'h00;
            score2 <= 8'h00;
            winner <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            armed  <= armed_nxt;
            score1 <= score1_nxt;
            score2 <= score2_nxt;
            winner <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        armed_nxt  = armed;
        score1_nxt = score1;
        score2_nxt = score2;
        winner_nxt = winner;
        won        = 1'b0;
        case (state)
            NEWGAME: begin
                // A button held since entry must be released before it can start a game.
                if (btn == 4'd0) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    score1_nxt = 8'h00;
                    score2_nxt = 8'h00;
                    timer_nxt  = SERVE_T;
                    armed_nxt  = 1'b0;
                    state_nxt  = SERVE;
                end
            end
            SERVE: begin
                if (timer == 8'd0)
                    state_nxt = PLAY;
                else if (tick)
                    timer_nxt = timer - 8'd1;
            end
            PLAY: begin
                // Leaving PLAY on the first flag cycle keeps a persistent flag from double-counting.
                if (pts_1 || pts_2) begin
                    if (pts_1) begin
                        score1_nxt = inc1;
                        won        = (inc1 == WIN_BCD);
                    end else begin
                        score2_nxt = inc2;
                        won        = (inc2 == WIN_BCD);
                    end
                    if (won) begin
                        winner_nxt = ~pts_1;
                        timer_nxt  = OVER_T;
                        state_nxt  = OVER;
                    end else begin
                        timer_nxt  = SERVE_T;
                        state_nxt  = SERVE;
                    end
                end
            end
            OVER: begin
                if (timer == 8'd0) begin
                    armed_nxt = 1'b0;
                    state_nxt = NEWGAME;
                end else if (tick) begin
                    timer_nxt = timer - 8'd1;
                end
            end
            default: state_nxt = NEWGAME;
        endcase
    end

    always_comb begin
        gra_still = (state != PLAY);
        new_game  = (state == NEWGAME);
        game_over = (state == OVER);
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized and directed bench for pong_game_ctrl against a score/phase model
// kept in plain integers.
module tb_pong_game_ctrl;

    localparam int WIN = 10;
    localparam int SRV = 120;
    localparam int OVR = 180;

    localparam int P_NEW  = 0;
    localparam int P_SRV  = 1;
    localparam int P_PLAY = 2;
    localparam int P_OVER = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'd0;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       pts_1 = 1'b0;
    logic       pts_2 = 1'b0;
    logic       gra_still;
    logic [7:0] score1;
    logic [7:0] score2;
    logic       new_game;
    logic       game_over;
    logic       winner;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    int m_phase, m_s1, m_s2, m_timer;
    bit m_armed, m_winner;

    always #5 clk = ~clk;

    pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(SRV), .OVER_TICKS(OVR)) dut (
        .clk(clk), .reset(reset), .btn(btn), .x(x), .y(y),
        .pts_1(pts_1), .pts_2(pts_2), .gra_still(gra_still),
        .score1(score1), .score2(score2), .new_game(new_game),
        .game_over(game_over), .winner(winner)
    );

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules in integer scores and a phase number.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= P_NEW; m_s1 <= 0; m_s2 <= 0;
            m_timer <= 0; m_armed <= 1'b0; m_winner <= 1'b0;
        end else begin
            case (m_phase)
                P_NEW: begin
                    if (btn == 4'd0) m_armed <= 1'b1;
                    else if (m_armed) begin
                        m_s1 <= 0; m_s2 <= 0; m_timer <= SRV;
                        m_armed <= 1'b0; m_phase <= P_SRV;
                    end
                end
                P_SRV: begin
                    if (m_timer == 0) m_phase <= P_PLAY;
                    else if (y == 10'd481 && x == 10'd0) m_timer <= m_timer - 1;
                end
                P_PLAY: begin
                    if (pts_1 || pts_2) begin
                        if (pts_1) m_s1 <= m_s1 + 1;
                        else       m_s2 <= m_s2 + 1;
                        if ((pts_1 ? m_s1 : m_s2) + 1 == WIN) begin
                            m_winner <= !pts_1; m_timer <= OVR; m_phase <= P_OVER;
                        end else begin
                            m_timer <= SRV; m_phase <= P_SRV;
                        end
                    end
                end
                default: begin
                    if (m_timer == 0) begin
                        m_armed <= 1'b0; m_phase <= P_NEW;
                    end else if (y == 10'd481 && x == 10'd0) begin
                        m_timer <= m_timer - 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("gra_still", 8'(gra_still), 8'(m_phase != P_PLAY));
            check("new_game",  8'(new_game),  8'(m_phase == P_NEW));
            check("game_over", 8'(game_over), 8'(m_phase == P_OVER));
            check("score1",    score1,        to_bcd(m_s1));
            check("score2",    score2,        to_bcd(m_s2));
            check("winner",    8'(winner),    8'(m_winner));
        end
    end

    task automatic cyc(input logic [3:0] b, input bit tk, input logic p1, input logic p2);
        btn = b; pts_1 = p1; pts_2 = p2;
        if (tk) begin
            x = 10'd0; y = 10'd481;
        end else begin
            case ($urandom_range(0, 7))
                0: begin x = 10'd1; y = 10'd481; end
                1: begin x = 10'd0; y = 10'd480; end
                2: begin x = 10'd0; y = 10'd482; end
                default: begin
                    x = 10'($urandom_range(0, 799));
                    y = 10'($urandom_range(0, 524));
                    if (x == 10'd0 && y == 10'd481) x = 10'd1;
                end
            endcase
        end
        @(posedge clk); #1;
    endtask

    task automatic serve_to_play();
        int n = 0;
        while (gra_still && n < 2000) begin
            cyc(4'd0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        if (gra_still) begin
            vectors++; miscompares++;
            $display("FAIL serve_timeout: gra_still got 1 expected 0 after %0d cycles", n);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_still", 8'(gra_still), 8'd1);
        check("rst_new",   8'(new_game),  8'd1);
        check("rst_over",  8'(game_over), 8'd0);
        check("rst_s1",    score1,        8'h00);
        check("rst_s2",    score2,        8'h00);
        check("rst_win",   8'(winner),    8'd0);
        check_en = 1'b1;
        reset = 1'b0;

        // Start, then exactly 120 ticks of serve delay.
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b0, 1'b0, 1'b0);
        check("start_new", 8'(new_game), 8'd0);
        for (int i = 0; i < 119; i++) cyc(4'd0, 1'b1, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        check("serve_119", 8'(gra_still), 8'd1);
        cyc(4'd0, 1'b1, 1'b0, 1'b0);
        check("serve_120", 8'(gra_still), 8'd1);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        check("play_still", 8'(gra_still), 8'd0);
        check("play_s1", score1, 8'h00);
        check("play_s2", score2, 8'h00);

        // pts_1 held for three cycles counts once.
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        check("pts_still", 8'(gra_still), 8'd1);
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        check("pts_held_s1", score1, 8'h01);
        check("pts_held_s2", score2, 8'h00);

        // Simultaneous flags credit player 1.
        serve_to_play();
        cyc(4'd0, 1'b0, 1'b1, 1'b1);
        check("both_s1", score1, 8'h02);
        check("both_s2", score2, 8'h00);
        check("both_over", 8'(game_over), 8'd0);

        // Run player 1 up through 09 to the winning 10.
        for (int i = 0; i < 8; i++) begin
            serve_to_play();
            cyc(4'd0, 1'b0, 1'b1, 1'b0);
        end
        check("win_s1",    score1,        8'h10);
        check("win_over",  8'(game_over), 8'd1);
        check("win_who",   8'(winner),    8'd0);
        check("win_still", 8'(gra_still), 8'd1);
        for (int i = 0; i < 179; i++) cyc(4'd0, 1'b1, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        check("over_179", 8'(game_over), 8'd1);
        cyc(4'd0, 1'b1, 1'b0, 1'b0);
        check("over_180", 8'(game_over), 8'd1);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        check("back_new",  8'(new_game), 8'd1);
        check("held_s1",   score1,       8'h10);

        // Button held through reset release must not start a game.
        btn = 4'd1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(4'd1, 1'b0, 1'b0, 1'b0);
        check("held_btn_new", 8'(new_game), 8'd1);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        cyc(4'd1, 1'b0, 1'b0, 1'b0);
        check("release_press", 8'(new_game), 8'd0);

        // Player 2 to 07, then reset mid-serve with 50 ticks left.
        for (int i = 0; i < 7; i++) begin
            serve_to_play();
            cyc(4'd0, 1'b0, 1'b0, 1'b1);
        end
        check("p2_seven", score2, 8'h07);
        for (int i = 0; i < 70; i++) cyc(4'd0, 1'b1, 1'b0, 1'b0);
        check("mid_serve", 8'(gra_still), 8'd1);
        reset = 1'b1;
        #1;
        check("async_new", 8'(new_game), 8'd1);
        check("async_s1",  score1,       8'h00);
        check("async_s2",  score2,       8'h00);
        #1;
        reset = 1'b0;

        // Randomized play against the model.
        for (int i = 0; i < 30000; i++) begin
            logic [3:0] b;
            if ($urandom_range(0, 4999) == 0) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
            b = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(0, 15));
            cyc(b, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
